// File: rtl/delay_step_sequencer_if.sv
// Step-sequencer bundle: run/error control, live sample, delay-stage handshake and captured result.
// DELAY_SEQ_STATS_EN adds the max_busy/ovr_cnt statistics signals.
interface delay_step_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             run;
    logic             clr_err;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] x_out;
    logic             sta;
    logic             done_sig;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] y_out;
    logic             y_valid;
    logic             busy;
    logic [CNT_W-1:0] step_cnt;
    logic             err_timeout;
    logic             err_overrun;
`ifdef DELAY_SEQ_STATS_EN
    logic [7:0]       max_busy;
    logic [7:0]       ovr_cnt;
`endif

    modport master (
        input  run, clr_err, x_in, done_sig, y_in,
        output x_out, sta, y_out, y_valid, busy, step_cnt, err_timeout, err_overrun
`ifdef DELAY_SEQ_STATS_EN
        , output max_busy, ovr_cnt
`endif
    );

    modport slave (
        output run, clr_err, x_in, done_sig, y_in,
        input  x_out, sta, y_out, y_valid, busy, step_cnt, err_timeout, err_overrun
`ifdef DELAY_SEQ_STATS_EN
        , input max_busy, ovr_cnt
`endif
    );
endinterface

// File: rtl/delay_step_sequencer.sv
// Per-step controller: freezes x_in, holds sta until done_sig, captures y_in; flags timeout/overrun.
// Latency: tick T -> sta T+1; done_sig at cycle D -> y_out/y_valid at D+1. Optional DELAY_SEQ_STATS_EN.
// Backpressure: none queued; a tick arriving while a step is in flight is dropped and flagged.
module delay_step_sequencer #(
    parameter int WIDTH       = 32,
    parameter int STEP_PERIOD = 100,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    delay_step_sequencer_if.master  bus
);
    localparam int PC_W   = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(STEP_PERIOD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  y_q;
    logic [CNT_W-1:0]  step_q;
    logic              sta_q;
    logic              y_valid_q;
    logic              err_tmo_q;
    logic              err_ovr_q;

    logic tick;
    logic ovr_evt;
    logic busy_exit;
    logic tmo_evt;

    assign tick      = bus.run && (pc == '0);
    assign ovr_evt   = tick && (state != IDLE);
    assign busy_exit = (state == BUSY) && (bus.done_sig || (wait_cnt == WAIT_LAST));
    assign tmo_evt   = (state == BUSY) && !bus.done_sig && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (!bus.run) begin
            pc <= '0;
        end else if (pc == PC_LAST) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            step_q    <= '0;
            sta_q     <= 1'b0;
            y_valid_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        x_q      <= bus.x_in;
                        sta_q    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // done_sig outranks the timeout when both land on the last wait cycle
                    if (bus.done_sig) begin
                        sta_q     <= 1'b0;
                        y_q       <= bus.y_in;
                        y_valid_q <= 1'b1;
                        state     <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        sta_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    step_q <= step_q + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (bus.clr_err) begin
                err_tmo_q <= 1'b0;
                err_ovr_q <= 1'b0;
            end
            if (tmo_evt) err_tmo_q <= 1'b1;
            if (ovr_evt) err_ovr_q <= 1'b1;
        end
    end

    assign bus.x_out       = x_q;
    assign bus.sta         = sta_q;
    assign bus.y_out       = y_q;
    assign bus.y_valid     = y_valid_q;
    assign bus.busy        = (state == BUSY);
    assign bus.step_cnt    = step_q;
    assign bus.err_timeout = err_tmo_q;
    assign bus.err_overrun = err_ovr_q;

`ifdef DELAY_SEQ_STATS_EN
    logic [7:0]  max_busy_q;
    logic [7:0]  ovr_cnt_q;
    logic [31:0] busy_len;
    logic [7:0]  busy_len8;

    // length of the BUSY stretch that ends this cycle, saturated to 8 bits
    assign busy_len  = 32'(wait_cnt) + 32'd1;
    assign busy_len8 = (busy_len > 32'd255) ? 8'hFF : busy_len[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_busy_q <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            if (bus.clr_err) begin
                max_busy_q <= '0;
                ovr_cnt_q  <= '0;
            end
            if (busy_exit && (bus.clr_err || (busy_len8 > max_busy_q))) begin
                max_busy_q <= busy_len8;
            end
            if (ovr_evt) begin
                if (bus.clr_err)              ovr_cnt_q <= 8'd1;
                else if (ovr_cnt_q != 8'hFF)  ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end
        end
    end

    assign bus.max_busy = max_busy_q;
    assign bus.ovr_cnt  = ovr_cnt_q;
`else
    logic unused_exit;
    assign unused_exit = busy_exit;
`endif
endmodule

// File: tb/tb_delay_step_sequencer.sv
// Directed bench for delay_step_sequencer (STEP_PERIOD=20, TIMEOUT=64, CNT_W=4) with a y_out scoreboard.
module tb_delay_step_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delay_step_sequencer_if #(.WIDTH(32), .CNT_W(4)) dif ();

    delay_step_sequencer #(
        .WIDTH(32), .STEP_PERIOD(20), .TIMEOUT(64), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.master)
    );

    localparam logic [31:0] Y_OFS = 32'h0080_0000;

    // downstream model: one-cycle done pulse dly cycles after sta rises; y = x + Y_OFS
    int          dly = 5;
    logic [63:0] sh  = '0;
    always @(posedge clk) sh <= {sh[62:0], dif.sta};
    always_comb begin
        dif.done_sig = 1'b0;
        if (dly > 0) dif.done_sig = sh[dly-1] && !sh[dly];
    end
    assign dif.y_in = dif.x_out + Y_OFS;

    int          n_cmp = 0;
    int          n_err = 0;
    int          yv_cnt = 0;
    logic        yv_prev = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (dif.y_valid) begin
            yv_cnt++;
            chk("yv_single_cycle", yv_prev, 0);
            chk("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("sb_y_out", dif.y_out, exp_q.pop_front());
        end
        yv_prev = dif.y_valid;
    end

    initial begin
        int n;
        int yv0;
        rst = 1'b0; dif.run = 1'b0; dif.clr_err = 1'b0; dif.x_in = '0;
        cyc(3);
        chk("rst_sta", dif.sta, 0);
        chk("rst_busy", dif.busy, 0);
        chk("rst_x_out", dif.x_out, 0);
        chk("rst_y_out", dif.y_out, 0);
        chk("rst_y_valid", dif.y_valid, 0);
        chk("rst_step_cnt", dif.step_cnt, 0);
        chk("rst_errs", {dif.err_timeout, dif.err_overrun}, 0);
        rst = 1'b1;
        cyc(2);

        // nominal steps, 5-cycle downstream
        dif.x_in = 32'h3F80_0000;
        repeat (3) exp_q.push_back(32'h4000_0000);
        dif.run = 1'b1;
        cyc(1);
        chk("t1_sta_rise", dif.sta, 1);
        chk("t1_x_out", dif.x_out, 32'h3F80_0000);
        for (int i = 2; i <= 7; i++) begin
            cyc(1);
            chk("t1_yv_latency", dif.y_valid, (i == 7));
        end
        chk("t1_sta_fall", dif.sta, 0);
        cyc(1);
        chk("t1_step_cnt", dif.step_cnt, 1);
        cyc(12);
        chk("t1_gap_before_tick", dif.sta, 0);
        cyc(1);
        chk("t1_second_sta", dif.sta, 1);
        cyc(27);
        dif.run = 1'b0;
        chk("t1_step_cnt3", dif.step_cnt, 3);
        chk("t1_sb_empty", exp_q.size(), 0);
        cyc(30);
        chk("t1_stopped_sta", dif.sta, 0);
        chk("t1_stopped_cnt", dif.step_cnt, 3);

        // timeout: downstream never answers
        dly = 0;
        yv0 = yv_cnt;
        dif.run = 1'b1;
        cyc(1);
        chk("t2_sta_rise", dif.sta, 1);
        n = 0;
        while (dif.sta && n < 200) begin cyc(1); n++; end
        chk("t2_sta_len", n, 64);
        chk("t2_err_timeout", dif.err_timeout, 1);
        chk("t2_err_overrun", dif.err_overrun, 1);
        chk("t2_no_y_valid", yv_cnt, yv0);
        chk("t2_step_cnt", dif.step_cnt, 3);
        n = 0;
        while (!dif.sta && n < 40) begin cyc(1); n++; end
        chk("t2_next_step_delay", n, 16);
        dif.run = 1'b0;
        dif.clr_err = 1'b1;
        cyc(1);
        dif.clr_err = 1'b0;
        chk("t2_clr_timeout", dif.err_timeout, 0);
        chk("t2_clr_overrun", dif.err_overrun, 0);
        cyc(70);
        chk("t2_second_timeout", dif.err_timeout, 1);
        chk("t2_idle_after", dif.busy, 0);
        dif.clr_err = 1'b1;
        cyc(1);
        dif.clr_err = 1'b0;
        chk("t2_clr_again", dif.err_timeout, 0);

        // overrun: step outlasts the period, every second tick dropped
        dly = 25;
        dif.x_in = 32'h1234_5678;
        repeat (2) exp_q.push_back(32'h1234_5678 + Y_OFS);
        dif.run = 1'b1;
        cyc(79);
        dif.run = 1'b0;
        cyc(10);
        chk("t3_step_cnt", dif.step_cnt, 5);
        chk("t3_err_overrun", dif.err_overrun, 1);
        chk("t3_err_timeout", dif.err_timeout, 0);
        chk("t3_sb_empty", exp_q.size(), 0);
        dif.clr_err = 1'b1;
        cyc(1);
        dif.clr_err = 1'b0;

        // run dropped mid-step; x_in changes after the freeze
        dly = 5;
        yv0 = yv_cnt;
        dif.x_in = 32'h3F00_0000;
        exp_q.push_back(32'h3F80_0000);
        dif.run = 1'b1;
        cyc(1);
        chk("t4_sta_rise", dif.sta, 1);
        cyc(2);
        dif.run = 1'b0;
        dif.x_in = 32'h4040_0000;
        cyc(1);
        chk("t4_x_frozen", dif.x_out, 32'h3F00_0000);
        cyc(10);
        chk("t4_one_y_valid", yv_cnt, yv0 + 1);
        chk("t4_step_cnt", dif.step_cnt, 6);
        cyc(30);
        chk("t4_sta_stays_low", dif.sta, 0);
        exp_q.push_back(32'h40C0_0000);
        dif.run = 1'b1;
        cyc(1);
        chk("t4_restart_sta", dif.sta, 1);
        cyc(10);
        dif.run = 1'b0;
        chk("t4_step_cnt7", dif.step_cnt, 7);
        cyc(5);

        // step_cnt wraps at 2^CNT_W
        dif.x_in = 32'h4120_0000;
        repeat (9) exp_q.push_back(32'h41A0_0000);
        dif.run = 1'b1;
        cyc(150);
        chk("t6_step_cnt15", dif.step_cnt, 15);
        cyc(19);
        dif.run = 1'b0;
        cyc(5);
        chk("t6_wrap_zero", dif.step_cnt, 0);
        chk("t6_no_errs", {dif.err_timeout, dif.err_overrun}, 0);
        chk("t6_sb_empty", exp_q.size(), 0);

        // asynchronous reset in the middle of a step
        dly = 0;
        dif.run = 1'b1;
        cyc(5);
        chk("t5_busy_before", dif.busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_sta", dif.sta, 0);
        chk("t5_rst_busy", dif.busy, 0);
        chk("t5_rst_y_out", dif.y_out, 0);
        chk("t5_rst_x_out", dif.x_out, 0);
        chk("t5_rst_step_cnt", dif.step_cnt, 0);
        chk("t5_rst_errs", {dif.err_timeout, dif.err_overrun}, 0);
        cyc(1);
        dif.run = 1'b0;
        rst = 1'b1;
        cyc(10);
        chk("t5_idle_after", {dif.busy, dif.sta}, 0);
        dly = 5;
        dif.x_in = 32'h3F80_0000;
        exp_q.push_back(32'h4000_0000);
        dif.run = 1'b1;
        cyc(10);
        dif.run = 1'b0;
        chk("t5_step_after_rst", dif.step_cnt, 1);
        chk("t5_sb_empty", exp_q.size(), 0);
`ifdef DELAY_SEQ_STATS_EN
        chk("stats_max_busy", dif.max_busy, 6);
        chk("stats_ovr_cnt", dif.ovr_cnt, 0);
`endif
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
